// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Immediate format select carried with each instruction.
  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_BAD = 3'b111
  } imm_src_e;

  // Stage occupancy: number of held entries (OUT, OUT+SKID).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate extender: instr + format select -> XLEN immediate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake at this level.
// Ports: instr (32b instruction), imm_src (format), imm (XLEN result),
//        illegal (format 111 selected, imm forced to zero).
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  imm_src_e        imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Every format is first assembled as a signed 32-bit value; the final
  // size cast then sign-extends to XLEN. Zero-extended formats keep bit31
  // clear, so the same cast works for them too.
  logic signed [31:0] v32;

  always_comb begin
    v32     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:  v32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  v32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  v32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      IMM_J:  v32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      IMM_U:  v32 = {instr[31:12], 12'b0};
      IMM_Z:  v32 = {27'b0, instr[19:15]};
      // RV64 shifts take a 6-bit shamt, RV32 only 5 bits.
      IMM_SH: v32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      default: begin
        v32     = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign imm = XLEN'(v32);

endmodule

// File: rtl/imm_gen_stage.sv
// Pipeline stage: decodes the immediate at the input and holds it in a 2-entry OUT+SKID buffer.
// Latency: 1 cycle from input transfer to out_valid when OUT is empty or draining.
// Backpressure: in_ready is registered (= SKID free); no combinational out_ready -> in_ready path.
// Ports: in_valid/in_ready/in_instr/in_tag/in_imm_src (upstream),
//        out_valid/out_ready/out_imm/out_tag/out_illegal (downstream), flush (sync discard).
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [2:0]       in_imm_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic             illegal;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
  } entry_t;

  entry_t          in_ent;
  entry_t          out_q;
  entry_t          skid_q;
  occ_e            state;
  logic            out_valid_q;
  logic            in_ready_q;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            in_xfer;
  logic            out_xfer;

  // Decode before storage so both OUT and SKID hold finished results.
  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm_src (imm_src_e'(in_imm_src)),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign in_ent   = '{illegal: dec_illegal, tag: in_tag, imm: dec_imm};
  assign in_xfer  = in_valid && in_ready_q;
  assign out_xfer = out_valid_q && out_ready;

  // out_valid/in_ready are updated alongside the state so both come
  // straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (flush) begin
      // Flush wins over any concurrent transfer; a concurrent input is dropped.
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            out_q       <= in_ent;
            state       <= ST_ONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            // OUT stalled: park the newcomer in SKID and close the input.
            skid_q     <= in_ent;
            state      <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            out_q <= in_ent;
          end else if (out_xfer) begin
            state       <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain can happen.
          if (out_xfer) begin
            out_q      <= skid_q;
            state      <= ST_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven by shared stimulus.
// Latency: checks one-cycle result after each accepted input.
// Backpressure: covers skid fill, in-order drain, flush and mid-stream reset.
module tb_imm_gen_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_tag;
  logic [2:0]  in_imm_src;
  logic        out_ready;

  logic        ir32, ov32, ill32;
  logic [31:0] imm32, tag32;
  logic        ir64, ov64, ill64;
  logic [63:0] imm64;
  logic [31:0] tag64;

  int n_cmp = 0;
  int n_bad = 0;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir32), .in_instr(in_instr), .in_tag(in_tag),
    .in_imm_src(in_imm_src),
    .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32),
    .out_illegal(ill32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(ir64), .in_instr(in_instr), .in_tag(in_tag),
    .in_imm_src(in_imm_src),
    .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64),
    .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [31:0] tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // I-type input whose immediate equals the tag, so imm and tag can be cross-checked.
  task automatic put(input logic [11:0] t);
    in_imm_src = 3'b000;
    in_instr   = {t, 20'b0};
    in_tag     = {20'b0, t};
    in_valid   = 1'b1;
  endtask

  initial begin
    vt[0] = '{3'b000, 32'h98D00000, 32'hA0, 32'hFFFFF98D, 64'hFFFFFFFFFFFFF98D, 1'b0};
    vt[1] = '{3'b001, 32'hFE000F80, 32'hA1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[2] = '{3'b010, 32'hFE000F80, 32'hA2, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1'b0};
    vt[3] = '{3'b011, 32'h7FFFF000, 32'hA3, 32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};
    vt[4] = '{3'b100, 32'hFFFFF000, 32'hA4, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
    vt[5] = '{3'b101, 32'h800A8000, 32'hA5, 32'h00000015, 64'h0000000000000015, 1'b0};
    vt[6] = '{3'b110, 32'h83F00000, 32'hA6, 32'h0000001F, 64'h000000000000003F, 1'b0};
    vt[7] = '{3'b111, 32'hFFFFFFFF, 32'hA7, 32'h00000000, 64'h0000000000000000, 1'b1};
    vt[8] = '{3'b100, 32'h12345000, 32'hA8, 32'h12345000, 64'h0000000012345000, 1'b0};
    vt[9] = '{3'b000, 32'h7FF00000, 32'hA9, 32'h000007FF, 64'h00000000000007FF, 1'b0};

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
    in_imm_src = '0; out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", ov32, 0);
    chk("rst_in_ready", ir32, 1);
    chk("rst_out_imm", imm32, 0);
    chk("rst_out_tag", tag32, 0);
    chk("rst_out_illegal", ill32, 0);
    chk("rst_in_ready64", ir64, 1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Table: one vector at a time, result checked one cycle after transfer.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_idle_valid", i), ov32, 0);
      in_imm_src = vt[i].src; in_instr = vt[i].instr; in_tag = vt[i].tag;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid32", i), ov32, 1);
      chk($sformatf("v%0d_imm32", i), imm32, vt[i].e32);
      chk($sformatf("v%0d_tag32", i), tag32, vt[i].tag);
      chk($sformatf("v%0d_ill32", i), ill32, vt[i].ill);
      chk($sformatf("v%0d_valid64", i), ov64, 1);
      chk($sformatf("v%0d_imm64", i), imm64, vt[i].e64);
      chk($sformatf("v%0d_ill64", i), ill64, vt[i].ill);
    end

    // Backpressure: three back-to-back inputs against a stalled output.
    @(negedge clk);
    out_ready = 1'b0;
    put(12'd1);
    @(negedge clk);
    chk("bp_ready_after1", ir32, 1);
    chk("bp_valid_after1", ov32, 1);
    put(12'd2);
    @(negedge clk);
    chk("bp_ready_after2", ir32, 0);
    chk("bp_ready_after2_64", ir64, 0);
    put(12'd3);
    @(negedge clk);
    chk("bp_still_blocked", ir32, 0);
    chk("bp_hold_tag", tag32, 1);
    chk("bp_hold_imm", imm32, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_tag2", tag32, 2);
    chk("bp_drain_imm2", imm32, 2);
    chk("bp_ready_reopen", ir32, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_drain_tag3", tag32, 3);
    chk("bp_drain_valid3", ov32, 1);
    chk("bp_drain_tag3_64", tag64, 3);
    @(negedge clk);
    chk("bp_empty_after", ov32, 0);

    // Flush while FULL, with an input still offered.
    out_ready = 1'b0;
    put(12'd4);
    @(negedge clk);
    put(12'd5);
    @(negedge clk);
    chk("fl_full_ready", ir32, 0);
    put(12'd6);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_full_valid", ov32, 0);
    chk("fl_full_ready_after", ir32, 1);
    chk("fl_full_valid64", ov64, 0);
    @(negedge clk);
    chk("fl_full_stays_empty", ov32, 0);

    // Flush while ONE with a concurrent accepted-looking input: it must be dropped.
    put(12'd7);
    @(negedge clk);
    put(12'd8);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_one_valid", ov32, 0);
    chk("fl_one_ready", ir32, 1);
    @(negedge clk);
    chk("fl_one_dropped", ov32, 0);
    out_ready = 1'b1;

    // Reset pulse mid-stream while FULL.
    out_ready = 1'b0;
    put(12'd9);
    @(negedge clk);
    put(12'd10);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_full_ready", ir32, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_valid", ov32, 0);
    chk("rs_async_ready", ir32, 1);
    chk("rs_async_imm", imm32, 0);
    chk("rs_async_tag", tag32, 0);
    chk("rs_async_ill", ill32, 0);
    chk("rs_async_imm64", imm64, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    put(12'd11);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rs_first_accept_valid", ov32, 1);
    chk("rs_first_accept_tag", tag32, 11);
    @(negedge clk);
    chk("rs_old_discarded", ov32, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL declare parameter XLEN, default 32, datapath width (legal values 32 or 64).
REQ-002 SHALL declare parameter TAG_W, default 32, width of the sideband tag (e.g. PC) carried alongside each instruction.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assertion, active-low.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_instr (input, 32) and in_tag (input, TAG_W).
REQ-007 SHALL have port in_imm_src, input, 3, immediate format select:
- I=000, S=001, B=010, J=011, U=100;
- Z=101: CSR zimm, instr[19:15] zero-extended;
- SH=110: shamt, zero-extended; instr[25:20] when XLEN=64, instr[24:20] when XLEN=32.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_imm (output, XLEN) and out_tag (output, TAG_W).
REQ-009 SHALL have port out_illegal, output, 1, asserted when the held entry was accepted with in_imm_src=111.

Function
REQ-010 SHALL sign-extend I/S/B/J immediates from instr[31] to XLEN, with the standard RV field scatter (B and J have bit0=0).
REQ-011 SHALL build U as {instr[31:12],12'b0}, sign-extended to XLEN.
REQ-012 SHALL output out_imm=0 and out_illegal=1 for src 111.
REQ-013 SHALL transfer an input when in_valid&&in_ready, and an output when out_valid&&out_ready.
REQ-014 SHALL have a latency of exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
REQ-015 SHALL hold two entries, output register (OUT) plus skid register (SKID); state EMPTY/ONE/FULL per entry count.
REQ-016 SHALL drive in_ready = !SKID occupied; in_ready is a registered output with no combinational path from out_ready.
REQ-017 SHALL load an incoming entry into OUT when OUT is empty or draining in the same cycle; otherwise it goes into SKID.
REQ-018 SHALL, on an output transfer with SKID occupied, move SKID into OUT, and accept an incoming entry into SKID in the same cycle only if in_ready was 1.
REQ-019 SHALL, under out_valid&&!out_ready, hold out_imm, out_tag and out_illegal stable.
REQ-020 SHALL preserve ordering; no entry is duplicated or dropped except by flush.
REQ-021 SHALL, on flush, empty both entries at the next edge; flush has priority over simultaneous in/out transfers, and a concurrent input is dropped.
REQ-022 SHALL, in the cycle after flush, have out_valid=0 and in_ready=1.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0 and both entries empty.
REQ-024 SHALL discard any in-flight entry when reset asserts mid-operation, and accept input on the first clk edge after deassertion.

Structure
REQ-025 SHALL place the imm_src encoding enum (imm_src_e) and the XLEN default constant in shared package imm_pkg.
REQ-026 SHALL place the combinational extender in sub-module imm_decode (instr, imm_src, parameter XLEN -> imm, illegal), instantiated once at the input side.
REQ-027 SHALL keep the handshake/skid logic in imm_gen_stage only.

Verification
REQ-028 SHALL cover I-type: src=000, instr=32'h98D00000, XLEN=32 -> out_imm=32'hFFFFF98D one cycle after transfer.
REQ-029 SHALL cover S/B: instr=32'hFE000F80; src=001 -> 32'hFFFFFFFF; src=010 -> 32'hFFFFFFFE.
REQ-030 SHALL cover J/U and XLEN=64:
- J: src=011, instr=32'h7FFFF000 -> 32'h000FFFFE.
- U: src=100, instr=32'hFFFFF000 with XLEN=64 -> 64'hFFFFFFFFFFFFF000.
REQ-031 SHALL cover backpressure: three back-to-back inputs with out_ready=0 -> in_ready falls after the second; on out_ready=1 the entries exit in order with tags 1, 2, 3, and none is lost.
REQ-032 SHALL cover flush and illegal: flush while FULL -> next cycle out_valid=0, in_ready=1; src=111 -> out_imm=0, out_illegal=1.
REQ-033 SHALL cover reset mid-stream: rst_n low for 1 cycle while FULL -> outputs 0 immediately (asynchronous), in_ready=1.
